ica_frame_loader: RTL and testbench

//  Producer end of the FastICA matrix interface: collects streamed N-channel ECG samples

---
 rtl/ica_pkg.sv | 15 +
 rtl/ica_frame_bank.sv | 26 ++
 rtl/ica_frame_loader.sv | 188 ++++++++++++++++++
 tb/tb_ica_frame_loader.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ica_pkg.sv
// Shared types and constants for the FastICA frame loader.
package ica_pkg;

    localparam int unsigned SAMPLE_BITS = 32;
    localparam int unsigned FRAME_CNT_W = 16;

    typedef logic signed [SAMPLE_BITS-1:0] sample_t;

    typedef enum logic [1:0] {
        LD_FILL,
        LD_ISSUE,
        LD_WAIT
    } ld_state_e;

endpackage

// File: rtl/ica_frame_bank.sv
// One SIZE_N x SIZE_M sample store: column-wide write port, full parallel read-out.
module ica_frame_bank #(
    parameter int unsigned SIZE_N = 8,
    parameter int unsigned SIZE_M = 512,
    parameter int unsigned N_BITS = 32,
    localparam int unsigned COL_W = (SIZE_M > 1) ? $clog2(SIZE_M) : 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   wr_en,
    input  logic [COL_W-1:0]                       col,
    input  logic [SIZE_N-1:0][N_BITS-1:0]          data,
    output logic [SIZE_N-1:0][SIZE_M-1:0][N_BITS-1:0] mem
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem <= '0;
        end else if (wr_en) begin
            for (int ch = 0; ch < SIZE_N; ch++) begin
                mem[ch][col] <= data[ch];
            end
        end
    end

endmodule

// File: rtl/ica_frame_loader.sv
// Collects N-channel samples into an N x M frame and hands it to fast_ica (start/valid).
// ICA_LOADER_PINGPONG_EN: two banks so the next frame fills while the issued one is in use.
module ica_frame_loader
    import ica_pkg::*;
#(
    parameter int unsigned SIZE_N = 8,
    parameter int unsigned SIZE_M = 512,
    parameter int unsigned N_BITS = SAMPLE_BITS
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      s_valid,
    output logic                                      s_ready,
    input  logic [SIZE_N-1:0][N_BITS-1:0]             s_data,
    output logic [SIZE_N-1:0][SIZE_M-1:0][N_BITS-1:0] matrix,
    output logic                                      start,
    input  logic                                      ica_busy,
    input  logic                                      ica_valid,
    output logic [FRAME_CNT_W-1:0]                    frame_cnt,
    output logic                                      busy
);

    localparam int unsigned COL_W = (SIZE_M > 1) ? $clog2(SIZE_M) : 1;

    ld_state_e              state_q, state_d;
    logic [COL_W-1:0]       col_q, col_d;
    logic [FRAME_CNT_W-1:0] cnt_q, cnt_d;
    logic                   accept;
    logic                   last;

    assign accept    = s_valid && s_ready;
    assign last      = accept && (col_q == COL_W'(SIZE_M - 1));
    assign frame_cnt = cnt_q;

    always_comb begin
        col_d = col_q;
        if (last) begin
            col_d = '0;
        end else if (accept) begin
            col_d = col_q + COL_W'(1);
        end
    end

`ifdef ICA_LOADER_PINGPONG_EN
    logic rd_sel_q, rd_sel_d;
    // Back bank holds a complete frame queued behind the issued one.
    logic full_q, full_d;
    logic [SIZE_N-1:0][SIZE_M-1:0][N_BITS-1:0] mem0, mem1;

    assign s_ready = !full_q;
    assign matrix  = rd_sel_q ? mem1 : mem0;

    ica_frame_bank #(
        .SIZE_N (SIZE_N),
        .SIZE_M (SIZE_M),
        .N_BITS (N_BITS)
    ) u_bank0 (
        .clk   (clk),
        .rst   (rst),
        .wr_en (accept && rd_sel_q),
        .col   (col_q),
        .data  (s_data),
        .mem   (mem0)
    );

    ica_frame_bank #(
        .SIZE_N (SIZE_N),
        .SIZE_M (SIZE_M),
        .N_BITS (N_BITS)
    ) u_bank1 (
        .clk   (clk),
        .rst   (rst),
        .wr_en (accept && !rd_sel_q),
        .col   (col_q),
        .data  (s_data),
        .mem   (mem1)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rd_sel_d = rd_sel_q;
        full_d   = full_q;
        start    = 1'b0;
        busy     = 1'b0;
        unique case (state_q)
            LD_FILL: begin
                if (last) begin
                    state_d  = LD_ISSUE;
                    rd_sel_d = !rd_sel_q;
                end
            end
            LD_ISSUE: begin
                if (last) begin
                    full_d = 1'b1;
                end
                if (!ica_busy) begin
                    start   = 1'b1;
                    state_d = LD_WAIT;
                end
            end
            LD_WAIT: begin
                busy = 1'b1;
                if (ica_valid) begin
                    cnt_d = cnt_q + 1'b1;
                    if (full_q || last) begin
                        state_d  = LD_ISSUE;
                        rd_sel_d = !rd_sel_q;
                        full_d   = 1'b0;
                    end else begin
                        state_d = LD_FILL;
                    end
                end else if (last) begin
                    full_d = 1'b1;
                end
            end
            default: state_d = LD_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_sel_q <= 1'b0;
            full_q   <= 1'b0;
        end else begin
            rd_sel_q <= rd_sel_d;
            full_q   <= full_d;
        end
    end
`else
    assign s_ready = (state_q == LD_FILL);

    ica_frame_bank #(
        .SIZE_N (SIZE_N),
        .SIZE_M (SIZE_M),
        .N_BITS (N_BITS)
    ) u_bank0 (
        .clk   (clk),
        .rst   (rst),
        .wr_en (accept),
        .col   (col_q),
        .data  (s_data),
        .mem   (matrix)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        start   = 1'b0;
        busy    = 1'b0;
        unique case (state_q)
            LD_FILL: begin
                if (last) begin
                    state_d = LD_ISSUE;
                end
            end
            LD_ISSUE: begin
                if (!ica_busy) begin
                    start   = 1'b1;
                    state_d = LD_WAIT;
                end
            end
            LD_WAIT: begin
                busy = 1'b1;
                // Leaving WAIT makes a long ica_valid count only once.
                if (ica_valid) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = LD_FILL;
                end
            end
            default: state_d = LD_FILL;
        endcase
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= LD_FILL;
            col_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_ica_frame_loader.sv
// Directed bench for ica_frame_loader (SIZE_N=2, SIZE_M=4) with a frame-level reference model.
module tb_ica_frame_loader;
    import ica_pkg::*;

    localparam int unsigned N = 2;
    localparam int unsigned M = 4;
    localparam int unsigned W = 32;
`ifdef ICA_LOADER_PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif

    logic                       clk = 1'b0;
    logic                       rst = 1'b0;
    logic                       s_valid = 1'b0;
    logic                       ica_busy = 1'b0;
    logic                       ica_valid = 1'b0;
    logic [N-1:0][W-1:0]        s_data = '0;
    logic                       s_ready;
    logic                       start;
    logic                       busy;
    logic [N-1:0][M-1:0][W-1:0] matrix;
    logic [15:0]                frame_cnt;

    int checks = 0;
    int failures = 0;

    // Frame-level model: fill buffer, presented frame, queued frame, head-frame phase.
    int m_fill  [N][M];
    int m_shown [N][M];
    int m_queued[N][M];
    int m_col;
    int m_head;   // 0 none, 1 waiting for start, 2 handed to ICA
    bit m_back;
    int m_rel;
    int cnt_off = 0;

    always #5 clk = ~clk;

    ica_frame_loader #(
        .SIZE_N (N),
        .SIZE_M (M),
        .N_BITS (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .matrix    (matrix),
        .start     (start),
        .ica_busy  (ica_busy),
        .ica_valid (ica_valid),
        .frame_cnt (frame_cnt),
        .busy      (busy)
    );

    function automatic bit m_ready();
        return PP ? !m_back : (m_head == 0);
    endfunction

    task automatic model_reset();
        for (int ch = 0; ch < N; ch++) begin
            for (int c = 0; c < M; c++) begin
                m_fill[ch][c]   = 0;
                m_shown[ch][c]  = 0;
                m_queued[ch][c] = 0;
            end
        end
        m_col  = 0;
        m_head = 0;
        m_back = 1'b0;
        m_rel  = 0;
    endtask

    task automatic model_update();
        bit acc;
        if (!rst) return;
        acc = s_valid && m_ready();
        if (m_head == 2 && ica_valid) begin
            m_rel++;
            if (m_back) begin
                m_shown = m_queued;
                m_head  = 1;
                m_back  = 1'b0;
            end else begin
                m_head = 0;
            end
        end else if (m_head == 1 && !ica_busy) begin
            m_head = 2;
        end
        if (acc) begin
            for (int ch = 0; ch < N; ch++) m_fill[ch][m_col] = $signed(s_data[ch]);
            m_col++;
            if (m_col == M) begin
                m_col = 0;
                if (m_head == 0) begin
                    m_shown = m_fill;
                    m_head  = 1;
                end else begin
                    m_queued = m_fill;
                    m_back   = 1'b1;
                end
            end
        end
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        bit      mat_ok = 1'b1;
        sample_t got;
        int      exp_v;
        for (int ch = 0; ch < N; ch++) begin
            for (int c = 0; c < M; c++) begin
                got   = matrix[ch][c];
                exp_v = PP ? m_shown[ch][c] : m_fill[ch][c];
                if (got != exp_v) mat_ok = 1'b0;
            end
        end
        chk("s_ready", longint'(s_ready), longint'(m_ready()));
        chk("start", longint'(start), longint'(m_head == 1 && !ica_busy));
        chk("busy", longint'(busy), longint'(m_head == 2));
        chk("frame_cnt", longint'(frame_cnt), longint'((cnt_off + m_rel) & 16'hFFFF));
        chk("matrix_ok", longint'(mat_ok), 1);
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
    task automatic step();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic send(input int a, input int b);
        s_valid   = 1'b1;
        s_data[0] = W'(a);
        s_data[1] = W'(b);
        step();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        step();
        step();
        chk("rst_frame_cnt", longint'(frame_cnt), 0);
        chk("rst_s_ready", longint'(s_ready), 1);
        chk("rst_busy", longint'(busy), 0);
        rst = 1'b1;
        step();
    endtask

    initial begin
        model_reset();
        do_reset();

        // Back-to-back frame, fast_ica idle
        for (int i = 1; i <= 4; i++) send(i, -i);
        s_valid = 1'b0;
        chk("t1_start", longint'(start), 1);
        step();
        chk("t1_busy", longint'(busy), 1);
        chk("t1_s_ready", longint'(s_ready), 0);
        chk("t1_m01", longint'($signed(matrix[0][1])), 2);
        chk("t1_m13", longint'($signed(matrix[1][3])), -4);
        step();
        ica_valid = 1'b1;
        step();
        ica_valid = 1'b0;
        chk("t1_cnt", longint'(frame_cnt), 1);
        step();

        // ica_busy holds the start off; ica_valid before WAIT is ignored
        ica_busy = 1'b1;
        for (int i = 5; i <= 8; i++) send(i, -i);
        s_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ica_valid = (i == 2);
            step();
        end
        ica_busy  = 1'b0;
        ica_valid = 1'b1;   // coincides with the start cycle
        step();
        ica_valid = 1'b0;
        chk("t2_busy", longint'(busy), 1);
        chk("t2_cnt", longint'(frame_cnt), 1);

        // Source keeps pushing during WAIT; long ica_valid counts once
        for (int i = 0; i < 3; i++) send(100 + i, -100 - i);
`ifndef ICA_LOADER_PINGPONG_EN
        chk("t3_m00", longint'($signed(matrix[0][0])), 5);
`endif
        ica_valid = 1'b1;
        for (int i = 0; i < 3; i++) send(200 + i, -200 - i);
        ica_valid = 1'b0;
        s_valid   = 1'b0;
        chk("t3_cnt", longint'(frame_cnt), 2);
        step();

        // Reset mid-frame, then reset during WAIT
        do_reset();
        for (int i = 11; i <= 14; i++) send(i, -i);
        s_valid = 1'b0;
        step();
        step();
        do_reset();
        chk("t4_start", longint'(start), 0);
        for (int i = 21; i <= 24; i++) send(i, -i);
        s_valid = 1'b0;
        step();
        chk("t4_m00", longint'($signed(matrix[0][0])), 21);
        chk("t4_m13", longint'($signed(matrix[1][3])), -24);
        ica_valid = 1'b1;
        step();
        ica_valid = 1'b0;
        step();

`ifdef ICA_LOADER_PINGPONG_EN
        // Second frame fills while the first is with fast_ica
        for (int i = 1; i <= 4; i++) send(i, -i);
        for (int i = 10; i <= 13; i++) send(i, -i);
        s_valid = 1'b0;
        chk("pp_s_ready", longint'(s_ready), 0);
        step();
        step();
        ica_valid = 1'b1;
        step();
        ica_valid = 1'b0;
        chk("pp_start", longint'(start), 1);
        chk("pp_m00", longint'($signed(matrix[0][0])), 10);
        chk("pp_m03", longint'($signed(matrix[0][3])), 13);
        step();
        ica_valid = 1'b1;
        step();
        ica_valid = 1'b0;
        step();
`endif

        // Counter wrap: preload 0xFFFF while a frame is in WAIT
        for (int i = 31; i <= 34; i++) send(i, -i);
        s_valid = 1'b0;
        step();
        force dut.cnt_q = 16'hFFFF;
        cnt_off = 65535 - m_rel;
        step();
        release dut.cnt_q;
        step();
        chk("wrap_pre", longint'(frame_cnt), 65535);
        ica_valid = 1'b1;
        step();
        ica_valid = 1'b0;
        chk("wrap_cnt", longint'(frame_cnt), 0);
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
